// File: rtl/note_scroller_pkg.sv
// Shared constants for the note chart pipeline: FSM state encoding,
// screen geometry and lane positions, plus a saturating counter helper.
package note_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } scroll_state_e;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  // Lane x centres, left to right.
  localparam int LANE_X_0 = 300;
  localparam int LANE_X_1 = 400;
  localparam int LANE_X_2 = 500;
  localparam int LANE_X_3 = 600;

  localparam int COORD_W = 14;
  localparam int FRAME_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FRAME_W-1:0] sat_inc(input logic [FRAME_W-1:0] v);
    return (v == {FRAME_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/note_scroller_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-time debounce and
// a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // Debounce counter: flip the level after DB_CYCLES disagreeing cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, counter, level and pulse registers.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!clr_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign btn_rise = rise_q;

endmodule

// File: rtl/note_scroller.sv
// First-note anchor generator: scrolls ball_y once per frame during vsync
// under a play/pause/done state machine driven by the start button.
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int START_X   = 400,
  parameter int START_Y   = 0,
  parameter int END_Y     = 1960,
  parameter int H_TICK    = 0,
  parameter int V_TICK    = 0,
  parameter int DB_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [9:0]           hc,
  input  logic [9:0]           vc,
  input  logic                 btn_start,
  input  logic [2:0]           speed,
  input  logic                 loop_en,
  output logic [COORD_W-1:0]   ball_x,
  output logic [COORD_W-1:0]   ball_y,
  output logic                 playing,
  output logic                 paused,
  output logic                 song_done,
  output logic [FRAME_W-1:0]   frame_cnt
);

  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] END_Y_C   = COORD_W'(END_Y);
  localparam logic [COORD_W:0]   END_Y_W   = (COORD_W + 1)'(END_Y);

  scroll_state_e       state_q, state_d;
  logic [COORD_W-1:0]  ball_y_q, ball_y_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                song_done_q, song_done_d;
  logic                playing_q, playing_d;
  logic                paused_q, paused_d;
  logic                tick_q, tick_d;
  logic                start_evt;
  logic [COORD_W:0]    sum;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_start_btn (
    .clk      (clk),
    .clr_n    (clr_n),
    .btn_raw  (btn_start),
    .btn_rise (start_evt)
  );

  // Frame tick decode at the programmed vsync position.
  always_comb begin
    tick_d = (hc == 10'(H_TICK)) && (vc == 10'(V_TICK));
  end

  // Next-state, anchor update and status decode.
  always_comb begin
    state_d     = state_q;
    ball_y_d    = ball_y_q;
    frame_cnt_d = frame_cnt_q;
    song_done_d = 1'b0;
    // One bit wider than ball_y so the end-of-song compare never wraps.
    sum         = {1'b0, ball_y_q} + {{(COORD_W - 2){1'b0}}, speed};
    case (state_q)
      ST_IDLE: begin
        ball_y_d = START_Y_C;
        if (start_evt) begin
          state_d     = ST_RUN;
          frame_cnt_d = '0;
        end
      end
      ST_RUN: begin
        // A press on the tick cycle pauses without advancing that frame.
        if (start_evt) begin
          state_d = ST_PAUSE;
        end else if (tick_q) begin
          frame_cnt_d = sat_inc(frame_cnt_q);
          if (sum >= END_Y_W) begin
            ball_y_d    = END_Y_C;
            song_done_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            ball_y_d = sum[COORD_W-1:0];
          end
        end
      end
      ST_PAUSE: begin
        if (start_evt) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        ball_y_d = END_Y_C;
        if (loop_en) begin
          if (tick_q) begin
            ball_y_d    = START_Y_C;
            frame_cnt_d = '0;
            state_d     = ST_RUN;
          end
        end else if (start_evt) begin
          ball_y_d = START_Y_C;
          state_d  = ST_IDLE;
        end
      end
    endcase
    playing_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSE);
  end

  // State, anchor and status registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      ball_y_q    <= START_Y_C;
      frame_cnt_q <= '0;
      song_done_q <= 1'b0;
      playing_q   <= 1'b0;
      paused_q    <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_y_q    <= ball_y_d;
      frame_cnt_q <= frame_cnt_d;
      song_done_q <= song_done_d;
      playing_q   <= playing_d;
      paused_q    <= paused_d;
      tick_q      <= tick_d;
    end
  end

  assign ball_x    = COORD_W'(START_X);
  assign ball_y    = ball_y_q;
  assign playing   = playing_q;
  assign paused    = paused_q;
  assign song_done = song_done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller with a 8x4 VGA counter model
// (32 cycles per frame, tick position hc = 0, vc = 0).
module tb_note_scroller;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [4:0]  pos = 5'd0;
  logic [9:0]  hc, vc;
  logic        btn_start = 1'b0;
  logic [2:0]  speed = 3'd0;
  logic        loop_en = 1'b0;
  logic [13:0] ball_x, ball_y;
  logic        playing, paused, song_done;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;
  int done_base;

  note_scroller #(
    .DB_CYCLES (4)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .hc        (hc),
    .vc        (vc),
    .btn_start (btn_start),
    .speed     (speed),
    .loop_en   (loop_en),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .playing   (playing),
    .paused    (paused),
    .song_done (song_done),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Free-running VGA counter model: hc 0..7, vc 0..3.
  always @(posedge clk) pos <= pos + 5'd1;
  assign hc = {7'd0, pos[2:0]};
  assign vc = {8'd0, pos[4:3]};

  always @(negedge clk) if (song_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the cycle where the counter model sits at position p.
  // pos 0 is the hc=0/vc=0 cycle, pos 1 carries frame_tick, pos 2 shows the update.
  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (pos != 5'(p) && n < 64);
    if (pos != 5'(p)) check("wait_pos_timeout", 32'(pos), 32'(p));
  endtask

  // Press starting at position at_pos; the debounced pulse lands 6 cycles later.
  task automatic press(input int at_pos, input int hold);
    wait_pos(at_pos);
    btn_start = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    btn_start = 1'b0;
  endtask

  initial begin
    int exp_y;
    int exp_cnt;

    // 1. reset mid-frame
    repeat (13) @(posedge clk);
    #2;
    check("rst_ball_x", 32'(ball_x), 32'd400);
    check("rst_ball_y", 32'(ball_y), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_done", 32'(song_done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    // 2. short press is filtered; 6-cycle press with a later glitch gives one event
    speed = 3'd5;
    press(10, 3);
    repeat (12) @(posedge clk);
    #1;
    check("short_press_playing", 32'(playing), 32'd0);
    wait_pos(10);
    btn_start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    btn_start = 1'b0;
    @(posedge clk);
    #1;
    btn_start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    btn_start = 1'b0;
    check("glitch_playing", 32'(playing), 32'd1);
    check("glitch_paused", 32'(paused), 32'd0);
    check("start_frame_cnt", 32'(frame_cnt), 32'd0);

    // 3. ten frames at speed 5, value held through the tick cycle
    exp_y = 0;
    for (int f = 0; f < 10; f++) begin
      wait_pos(1);
      check("tick_cycle_hold", 32'(ball_y), 32'(exp_y));
      wait_pos(2);
      exp_y += 5;
      check("after_tick_y", 32'(ball_y), 32'(exp_y));
    end
    wait_pos(20);
    check("mid_frame_y", 32'(ball_y), 32'd50);
    check("run10_frame_cnt", 32'(frame_cnt), 32'd10);

    // 4. pause on the tick cycle, hold, resume on the tick cycle
    press(27, 6);
    wait_pos(2);
    check("pause_paused", 32'(paused), 32'd1);
    check("pause_playing", 32'(playing), 32'd0);
    check("pause_y", 32'(ball_y), 32'd50);
    repeat (3) wait_pos(2);
    check("paused_3f_y", 32'(ball_y), 32'd50);
    check("paused_3f_cnt", 32'(frame_cnt), 32'd10);
    press(27, 6);
    wait_pos(2);
    check("resume_playing", 32'(playing), 32'd1);
    check("resume_same_tick_y", 32'(ball_y), 32'd50);
    wait_pos(2);
    check("resume_next_y", 32'(ball_y), 32'd55);
    check("resume_next_cnt", 32'(frame_cnt), 32'd11);

    // 5. run to 1957, clamp to 1960, stop; press returns to IDLE
    speed = 3'd7;
    repeat (271) wait_pos(2);
    check("long_run_y", 32'(ball_y), 32'd1952);
    speed = 3'd5;
    wait_pos(2);
    check("preload_y", 32'(ball_y), 32'd1957);
    speed = 3'd7;
    done_base = done_cnt;
    wait_pos(2);
    check("clamp_y", 32'(ball_y), 32'd1960);
    check("clamp_done_pulse", 32'(song_done), 32'd1);
    check("clamp_playing", 32'(playing), 32'd0);
    check("clamp_cnt", 32'(frame_cnt), 32'd284);
    wait_pos(2);
    check("done_hold_y", 32'(ball_y), 32'd1960);
    check("done_pulse_count", 32'(done_cnt - done_base), 32'd1);
    check("done_pulse_low", 32'(song_done), 32'd0);
    press(10, 6);
    repeat (3) @(posedge clk);
    #1;
    check("idle_y", 32'(ball_y), 32'd0);
    check("idle_playing", 32'(playing), 32'd0);
    check("idle_paused", 32'(paused), 32'd0);

    // 6. looping song
    loop_en = 1'b1;
    press(10, 6);
    exp_cnt = 279;
    repeat (279) wait_pos(2);
    check("loop_run_y", 32'(ball_y), 32'd1953);
    check("loop_run_cnt", 32'(frame_cnt), 32'(exp_cnt));
    speed = 3'd4;
    wait_pos(2);
    check("loop_preload_y", 32'(ball_y), 32'd1957);
    speed = 3'd7;
    done_base = done_cnt;
    wait_pos(2);
    check("loop_clamp_y", 32'(ball_y), 32'd1960);
    check("loop_done_pulse", 32'(song_done), 32'd1);
    check("loop_done_cnt", 32'(frame_cnt), 32'd281);
    press(10, 6);
    wait_pos(2);
    check("reload_y", 32'(ball_y), 32'd0);
    check("reload_cnt", 32'(frame_cnt), 32'd0);
    check("reload_playing", 32'(playing), 32'd1);
    check("reload_done_count", 32'(done_cnt - done_base), 32'd1);
    wait_pos(2);
    check("reload_next_y", 32'(ball_y), 32'd7);
    check("reload_next_cnt", 32'(frame_cnt), 32'd1);
    speed = 3'd0;
    wait_pos(2);
    check("speed0_y", 32'(ball_y), 32'd7);
    check("speed0_cnt", 32'(frame_cnt), 32'd2);

    // 1b. asynchronous reset during RUN
    done_base = done_cnt;
    wait_pos(12);
    clr_n = 1'b0;
    #2;
    check("arst_y", 32'(ball_y), 32'd0);
    check("arst_playing", 32'(playing), 32'd0);
    check("arst_cnt", 32'(frame_cnt), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("arst_no_done", 32'(done_cnt - done_base), 32'd0);
    check("arst_ball_x", 32'(ball_x), 32'd400);
    clr_n = 1'b1;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
